// File: rtl/mac_clk_pkg.sv
// Shared definitions for the MAC clock-enable generator: speed encodings,
// divisor defaults, the priority speed decode and the channel state type.
package mac_clk_pkg;

    localparam logic [2:0] SPD_1000 = 3'b100;
    localparam logic [2:0] SPD_100  = 3'b010;
    localparam logic [2:0] SPD_10   = 3'b001;
    localparam logic [2:0] SPD_OFF  = 3'b000;

    localparam int DIV_100M_DEF     = 5;
    localparam int DIV_10M_DEF      = 50;
    localparam int CNT_W_DEF        = 6;
    localparam int LOCK_PERIODS_DEF = 4;

    typedef enum logic {
        IDLE,
        RUN
    } ch_state_t;

    // Reduce a raw select to one-hot: 1000M wins over 100M, which wins over 10M.
    function automatic logic [2:0] spd_decode(input logic [2:0] sel);
        if (sel[2])      return SPD_1000;
        else if (sel[1]) return SPD_100;
        else if (sel[0]) return SPD_10;
        else             return SPD_OFF;
    endfunction

endpackage

// File: rtl/mac_clk_ch.sv
// One MAC clock channel: period counter, adopted speed and (optionally) the
// lock counter. Speed changes are only adopted at the last cycle of a period.
// Optional feature: define MAC_CLK_LOCK_EN to add the lock counter and port.
module mac_clk_ch
    import mac_clk_pkg::*;
#(
    parameter int DIV_100M     = DIV_100M_DEF,
    parameter int DIV_10M      = DIV_10M_DEF,
    parameter int CNT_W        = CNT_W_DEF
`ifdef MAC_CLK_LOCK_EN
    ,
    parameter int LOCK_PERIODS = LOCK_PERIODS_DEF
`endif
) (
    input  logic       clk_125M,
    input  logic       reset,
    input  logic [2:0] speed_q,
    output logic       ce,
    output logic       clk_out,
    output logic [2:0] spd_act
`ifdef MAC_CLK_LOCK_EN
    ,
    output logic       lock
`endif
);

    ch_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] div_m1;
    logic [CNT_W-1:0] high_len;
    logic [2:0]       spd_dec, spd_nxt;
    logic             last;

    assign spd_dec = spd_decode(speed_q);

    // Period length (minus one) and high-phase length of the adopted speed.
    always_comb begin
        div_m1   = '0;
        high_len = '0;
        case (spd_act)
            SPD_1000: begin
                div_m1   = '0;
                high_len = CNT_W'(1);
            end
            SPD_100: begin
                div_m1   = CNT_W'(DIV_100M - 1);
                high_len = CNT_W'((DIV_100M + 1) / 2);
            end
            SPD_10: begin
                div_m1   = CNT_W'(DIV_10M - 1);
                high_len = CNT_W'((DIV_10M + 1) / 2);
            end
            default: ;
        endcase
    end

    // At 1000M div_m1 is 0 and cnt stays 0, so every cycle is a period end.
    assign last = (cnt == div_m1);

    // State, counter and adopted-speed register.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_125M) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            spd_act <= SPD_OFF;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            spd_act <= spd_nxt;
        end
    end

    // Next state: start from IDLE, wrap or re-speed only at the end of a period.
    always_comb begin
        // NOTE: hold values assigned first so no branch leaves a latch behind.
        state_nxt = state;
        cnt_nxt   = cnt;
        spd_nxt   = spd_act;
        case (state)
            IDLE: begin
                if (spd_dec != SPD_OFF) begin
                    state_nxt = RUN;
                    spd_nxt   = spd_dec;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                if (last) begin
                    cnt_nxt = '0;
                    if (spd_dec != spd_act) begin
                        spd_nxt = spd_dec;
                        if (spd_dec == SPD_OFF) state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ce      = (state == RUN) && (cnt == '0);
    assign clk_out = (state == RUN) && (cnt < high_len);

`ifdef MAC_CLK_LOCK_EN
    localparam int                LOCK_W   = $clog2(LOCK_PERIODS + 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_PERIODS);

    logic [LOCK_W-1:0] lock_cnt, lock_cnt_nxt;
    logic              adopt, wrap;

    // Count unchanged wraps, saturating; any adoption or IDLE restarts the count.
    always_comb begin
        adopt        = (state == IDLE) ? (spd_dec != SPD_OFF)
                                       : (last && (spd_dec != spd_act));
        wrap         = (state == RUN) && last && (spd_dec == spd_act);
        lock_cnt_nxt = lock_cnt;
        if (adopt || (state_nxt == IDLE)) begin
            lock_cnt_nxt = '0;
        end else if (wrap && (lock_cnt != LOCK_MAX)) begin
            lock_cnt_nxt = lock_cnt + LOCK_W'(1);
        end
    end

    // Lock counter register.
    always_ff @(posedge clk_125M) begin
        if (reset) lock_cnt <= '0;
        else       lock_cnt <= lock_cnt_nxt;
    end

    assign lock = (lock_cnt == LOCK_MAX);
`endif

endmodule

// File: rtl/mac_clk_en_gen.sv
// Multi-channel tri-speed MAC clock-enable generator. Registers the per-channel
// speed selects and drives one independent mac_clk_ch per channel.
// Optional feature: define MAC_CLK_LOCK_EN to add the per-channel lock output.
module mac_clk_en_gen
    import mac_clk_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int DIV_100M     = DIV_100M_DEF,
    parameter int DIV_10M      = DIV_10M_DEF,
    parameter int CNT_W        = CNT_W_DEF
`ifdef MAC_CLK_LOCK_EN
    ,
    parameter int LOCK_PERIODS = LOCK_PERIODS_DEF
`endif
) (
    input  logic                clk_125M,
    input  logic                reset,
    input  logic [3*NUM_CH-1:0] speed,
    output logic [NUM_CH-1:0]   ce,
    output logic [NUM_CH-1:0]   clk_out,
    output logic [3*NUM_CH-1:0] spd_act
`ifdef MAC_CLK_LOCK_EN
    ,
    output logic [NUM_CH-1:0]   lock
`endif
);

    logic [3*NUM_CH-1:0] speed_q;

    // Input register: every channel decision is taken from speed_q.
    always_ff @(posedge clk_125M) begin
        if (reset) speed_q <= '0;
        else       speed_q <= speed;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        mac_clk_ch #(
            .DIV_100M     (DIV_100M),
            .DIV_10M      (DIV_10M),
            .CNT_W        (CNT_W)
`ifdef MAC_CLK_LOCK_EN
            ,
            .LOCK_PERIODS (LOCK_PERIODS)
`endif
        ) u_ch (
            .clk_125M (clk_125M),
            .reset    (reset),
            .speed_q  (speed_q[3*c +: 3]),
            .ce       (ce[c]),
            .clk_out  (clk_out[c]),
            .spd_act  (spd_act[3*c +: 3])
`ifdef MAC_CLK_LOCK_EN
            ,
            .lock     (lock[c])
`endif
        );
    end

endmodule

// File: tb/tb_mac_clk_en_gen.sv
// Testbench for mac_clk_en_gen: directed scenarios plus randomized speed and
// reset traffic compared against a period-schedule reference model.
module tb_mac_clk_en_gen;

    localparam int NUM_CH       = 2;
    localparam int DIV_100M     = 5;
    localparam int DIV_10M      = 50;
    localparam int CNT_W        = 6;
    localparam int LOCK_PERIODS = 4;

    logic              clk_125M = 1'b0;
    logic              reset;
    logic [3*NUM_CH-1:0] speed;
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] clk_out;
    logic [3*NUM_CH-1:0] spd_act;
`ifdef MAC_CLK_LOCK_EN
    logic [NUM_CH-1:0] lock;
`endif

    int checks = 0;
    int errors = 0;

    always #4 clk_125M = ~clk_125M;

    mac_clk_en_gen #(
        .NUM_CH       (NUM_CH),
        .DIV_100M     (DIV_100M),
        .DIV_10M      (DIV_10M),
        .CNT_W        (CNT_W)
`ifdef MAC_CLK_LOCK_EN
        ,
        .LOCK_PERIODS (LOCK_PERIODS)
`endif
    ) dut (
        .clk_125M (clk_125M),
        .reset    (reset),
        .speed    (speed),
        .ce       (ce),
        .clk_out  (clk_out),
        .spd_act  (spd_act)
`ifdef MAC_CLK_LOCK_EN
        ,
        .lock     (lock)
`endif
    );

    // ---------------- reference model ----------------
    // Each channel is described by its adopted speed (4/2/1 = 1000/100/10M, 0 off)
    // and the cycle number at which its current run of periods began; the
    // position inside a period is (cycle - start) mod divisor.
    logic [2:0] m_sq    [NUM_CH] = '{default: 3'b000};
    int         m_act   [NUM_CH] = '{default: 0};
    int         m_start [NUM_CH] = '{default: 0};
    int         m_lk    [NUM_CH] = '{default: 0};
    int         cyc = 0;

    function automatic int m_decode(input logic [2:0] s);
        if (s[2]) return 4;
        if (s[1]) return 2;
        if (s[0]) return 1;
        return 0;
    endfunction

    function automatic int m_div(input int a);
        case (a)
            4:       return 1;
            2:       return DIV_100M;
            1:       return DIV_10M;
            default: return 1;
        endcase
    endfunction

    always @(posedge clk_125M) begin
        for (int c = 0; c < NUM_CH; c++) begin
            int dec, dv, nact, nstart, nlk;
            dec    = m_decode(m_sq[c]);
            dv     = m_div(m_act[c]);
            nact   = m_act[c];
            nstart = m_start[c];
            nlk    = m_lk[c];
            if (m_act[c] == 0) begin
                if (dec != 0) begin
                    nact = dec; nstart = cyc + 1; nlk = 0;
                end
            end else if ((cyc - m_start[c]) % dv == dv - 1) begin
                if (dec != m_act[c]) begin
                    nact = dec; nstart = cyc + 1; nlk = 0;
                end else if (m_lk[c] < LOCK_PERIODS) begin
                    nlk = m_lk[c] + 1;
                end
            end
            if (reset) begin
                nact = 0; nlk = 0;
            end
            m_act[c]   <= nact;
            m_start[c] <= nstart;
            m_lk[c]    <= nlk;
            m_sq[c]    <= reset ? 3'b000 : speed[3*c +: 3];
        end
        cyc <= cyc + 1;
    end

    function automatic logic exp_ce(input int c);
        if (m_act[c] == 0) return 1'b0;
        return ((cyc - m_start[c]) % m_div(m_act[c])) == 0;
    endfunction

    function automatic logic exp_clk(input int c);
        int dv;
        if (m_act[c] == 0) return 1'b0;
        dv = m_div(m_act[c]);
        return ((cyc - m_start[c]) % dv) < (dv + 1) / 2;
    endfunction

    // ---------------- helpers ----------------
    task automatic go(input int n);
        repeat (n) @(negedge clk_125M);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        speed = '0;
        go(2);
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        speed = 6'($urandom_range(0, 63));
        go(3);
        checks++;
        if (ce !== 2'b00) begin errors++; $display("FAIL reset_ce: got %b expected 00", ce); end
        checks++;
        if (clk_out !== 2'b00) begin errors++; $display("FAIL reset_clk_out: got %b expected 00", clk_out); end
        checks++;
        if (spd_act !== 6'b0) begin errors++; $display("FAIL reset_spd_act: got %b expected 000000", spd_act); end
`ifdef MAC_CLK_LOCK_EN
        checks++;
        if (lock !== 2'b00) begin errors++; $display("FAIL reset_lock: got %b expected 00", lock); end
`endif
        reset = 1'b0;
        speed = '0;
        go(1);
    endtask

    task automatic test_start_100m();
        logic       e_ce, e_clk;
        logic [2:0] e_spd;
        do_reset();
        speed = 6'b000_010;
        for (int i = 1; i <= 17; i++) begin
            go(1);
            if (i < 2) begin
                e_ce = 1'b0; e_clk = 1'b0; e_spd = 3'b000;
            end else begin
                e_ce = ((i - 2) % 5) == 0; e_clk = ((i - 2) % 5) < 3; e_spd = 3'b010;
            end
            checks++;
            if (ce[0] !== e_ce) begin errors++; $display("FAIL start100_ce cyc%0d: got %b expected %b", i, ce[0], e_ce); end
            checks++;
            if (clk_out[0] !== e_clk) begin errors++; $display("FAIL start100_clk cyc%0d: got %b expected %b", i, clk_out[0], e_clk); end
            checks++;
            if (spd_act[2:0] !== e_spd) begin errors++; $display("FAIL start100_spd cyc%0d: got %b expected %b", i, spd_act[2:0], e_spd); end
            checks++;
            if (ce[1] !== 1'b0) begin errors++; $display("FAIL start100_ch1_ce cyc%0d: got %b expected 0", i, ce[1]); end
        end
    endtask

    task automatic test_disable();
        logic [2:0] e_spd;
        do_reset();
        speed = 6'b000_010;
        go(4);                        // cnt = 2
        speed = '0;
        for (int i = 1; i <= 4; i++) begin
            go(1);                    // cnt = 3, 4, then IDLE
            e_spd = (i <= 2) ? 3'b010 : 3'b000;
            checks++;
            if (spd_act[2:0] !== e_spd) begin errors++; $display("FAIL disable_spd step%0d: got %b expected %b", i, spd_act[2:0], e_spd); end
            checks++;
            if (ce[0] !== 1'b0 || clk_out[0] !== 1'b0) begin
                errors++; $display("FAIL disable_out step%0d: got ce=%b clk=%b expected 0 0", i, ce[0], clk_out[0]);
            end
        end
    endtask

    task automatic test_mid_switch();
        do_reset();
        speed = 6'b000_001;
        go(12);                       // 10M, cnt = 10
        speed = 6'b000_010;
        for (int k = 11; k <= 49; k++) begin
            go(1);
            checks++;
            if (ce[0] !== 1'b0 || clk_out[0] !== (k < 25) || spd_act[2:0] !== 3'b001) begin
                errors++;
                $display("FAIL midswitch_hold cnt%0d: got ce=%b clk=%b spd=%b expected 0 %b 001",
                         k, ce[0], clk_out[0], spd_act[2:0], (k < 25));
            end
        end
        for (int j = 0; j <= 5; j++) begin
            go(1);
            checks++;
            if (ce[0] !== ((j % 5) == 0) || clk_out[0] !== ((j % 5) < 3) || spd_act[2:0] !== 3'b010) begin
                errors++;
                $display("FAIL midswitch_new pos%0d: got ce=%b clk=%b spd=%b expected %b %b 010",
                         j, ce[0], clk_out[0], spd_act[2:0], ((j % 5) == 0), ((j % 5) < 3));
            end
        end
    endtask

    task automatic test_1000m_indep();
        do_reset();
        speed = 6'b001_100;
        go(2);
        for (int i = 0; i < 110; i++) begin
            checks++;
            if (ce[0] !== 1'b1 || clk_out[0] !== 1'b1 || spd_act[2:0] !== 3'b100) begin
                errors++; $display("FAIL g1000_ch0 cyc%0d: got ce=%b clk=%b spd=%b expected 1 1 100", i, ce[0], clk_out[0], spd_act[2:0]);
            end
            checks++;
            if (ce[1] !== ((i % 50) == 0) || clk_out[1] !== ((i % 50) < 25) || spd_act[5:3] !== 3'b001) begin
                errors++;
                $display("FAIL g1000_ch1 cyc%0d: got ce=%b clk=%b spd=%b expected %b %b 001",
                         i, ce[1], clk_out[1], spd_act[5:3], ((i % 50) == 0), ((i % 50) < 25));
            end
            go(1);
        end
    endtask

    task automatic test_priority();
        do_reset();
        speed = 6'b000_111;
        go(2);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (spd_act[2:0] !== 3'b100 || ce[0] !== 1'b1) begin
                errors++; $display("FAIL priority_111 cyc%0d: got spd=%b ce=%b expected 100 1", i, spd_act[2:0], ce[0]);
            end
            go(1);
        end
        speed = 6'b000_011;           // decodes to 100M
        go(2);
        checks++;
        if (spd_act[2:0] !== 3'b010 || ce[0] !== 1'b1 || clk_out[0] !== 1'b1) begin
            errors++; $display("FAIL priority_011: got spd=%b ce=%b clk=%b expected 010 1 1", spd_act[2:0], ce[0], clk_out[0]);
        end
        go(1);
        checks++;
        if (ce[0] !== 1'b0) begin errors++; $display("FAIL priority_011_next: got ce=%b expected 0", ce[0]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        speed = 6'b000_001;
        go(22);                       // cnt = 20
        checks++;
        if (spd_act[2:0] !== 3'b001 || clk_out[0] !== 1'b1) begin
            errors++; $display("FAIL resetmid_pre: got spd=%b clk=%b expected 001 1", spd_act[2:0], clk_out[0]);
        end
        reset = 1'b1;
        go(1);
        checks++;
        if (spd_act !== 6'b0 || ce !== 2'b00 || clk_out !== 2'b00) begin
            errors++; $display("FAIL resetmid_post: got spd=%b ce=%b clk=%b expected 0 0 0", spd_act, ce, clk_out);
        end
        reset = 1'b0;
        speed = '0;
        go(1);
    endtask

`ifdef MAC_CLK_LOCK_EN
    task automatic test_lock();
        do_reset();
        speed = 6'b000_010;
        go(2);                        // first ce
        for (int i = 0; i <= 20; i++) begin
            checks++;
            if (lock[0] !== (i >= 20)) begin errors++; $display("FAIL lock_rise cyc%0d: got %b expected %b", i, lock[0], (i >= 20)); end
            if (i < 20) go(1);
        end
        speed = 6'b000_001;
        for (int j = 1; j <= 5; j++) begin
            go(1);
            checks++;
            if (lock[0] !== (j < 5)) begin errors++; $display("FAIL lock_adopt step%0d: got %b expected %b", j, lock[0], (j < 5)); end
        end
        checks++;
        if (spd_act[2:0] !== 3'b001 || ce[0] !== 1'b1) begin
            errors++; $display("FAIL lock_adopt_spd: got spd=%b ce=%b expected 001 1", spd_act[2:0], ce[0]);
        end
        for (int k = 1; k <= 200; k++) begin
            go(1);
            checks++;
            if (lock[0] !== (k >= 200)) begin errors++; $display("FAIL lock_rerise cyc%0d: got %b expected %b", k, lock[0], (k >= 200)); end
        end
    endtask
`endif

    task automatic test_random(input int n);
        do_reset();
        for (int i = 0; i < n; i++) begin
            go(1);
            for (int c = 0; c < NUM_CH; c++) begin
                checks++;
                if (ce[c] !== exp_ce(c)) begin
                    errors++; $display("FAIL rand_ce ch%0d cyc%0d: got %b expected %b", c, i, ce[c], exp_ce(c));
                end
                checks++;
                if (clk_out[c] !== exp_clk(c)) begin
                    errors++; $display("FAIL rand_clk ch%0d cyc%0d: got %b expected %b", c, i, clk_out[c], exp_clk(c));
                end
                checks++;
                if (spd_act[3*c +: 3] !== 3'(m_act[c])) begin
                    errors++; $display("FAIL rand_spd ch%0d cyc%0d: got %b expected %b", c, i, spd_act[3*c +: 3], 3'(m_act[c]));
                end
`ifdef MAC_CLK_LOCK_EN
                checks++;
                if (lock[c] !== (m_lk[c] == LOCK_PERIODS)) begin
                    errors++; $display("FAIL rand_lock ch%0d cyc%0d: got %b expected %b", c, i, lock[c], (m_lk[c] == LOCK_PERIODS));
                end
`endif
                if ($urandom_range(0, 29) == 0) speed[3*c +: 3] = 3'($urandom_range(0, 7));
            end
            reset = ($urandom_range(0, 599) == 0);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        speed = '0;
        test_reset();
        test_start_100m();
        test_disable();
        test_mid_switch();
        test_1000m_indep();
        test_priority();
        test_reset_mid();
`ifdef MAC_CLK_LOCK_EN
        test_lock();
`endif
        test_random(3000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no summary expected finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
